branch_multi: RTL and testbench
===============================

Name: branch_multi

Overview:
- NLANE-wide branch/jump resolution unit. Successor to the single-lane branch unit.
- Each lane is a two-stage pipeline: operand register, then compare/target/link.
- Mispredicts from all lanes, plus a held pending redirect, are age-arbitrated against the commit head. Only the oldest redirect is presented to commit, under a valid/ready handshake.
- Sits between the branch issue queues and commit/fetch-redirect logic.

Parameters:
- RV, 64, data width (32 or 64).
- NLANE, 2, number of branch lanes (1..4).
- NCOMMIT, 32, commit slots.
- LNCOMMIT, 5, log2(NCOMMIT).
- BDEC, 4, pc low bits reported as decode slot.
- CNTRL_SIZE, 7, control bits per lane.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  NLANE  lane issue valid.
- control  in  NLANE*CNTRL_SIZE  per lane: [5] predicted, [4] short_pc, [3] invert, [2:1] type (0 eq, 2 lt, 3 ltu; [1] pc_rel for jmp), [0] cjmp.
- r1, r2  in  NLANE*RV  operands.
- immed  in  NLANE*32  sign-extended offset.
- pc  in  NLANE*(RV-1)  pc[RV-1:1].
- branch_dest  in  NLANE*(RV-1)  predicted jump target.
- rd  in  NLANE*LNCOMMIT  commit slot.
- makes_rd  in  NLANE  lane writes link.
- commit_kill  in  NCOMMIT  squash slots.
- commit_head  in  LNCOMMIT  oldest live slot.
- res_rd  out  NLANE*LNCOMMIT  link writeback slot.
- res_makes_rd  out  NLANE  link writeback valid.
- result  out  NLANE*RV  link value.
- commit_br_valid  out  1  redirect pending.
- commit_br_ready  in  1  commit accepts redirect.
- commit_br  out  RV-1  redirect target[RV-1:1].
- commit_br_addr  out  LNCOMMIT  slot of redirecting branch.
- commit_br_short  out  1  redirecting branch was 16-bit.
- commit_br_dec  out  BDEC-1  pc[BDEC-1:1] of redirecting branch.

Behaviour:
- Reset (async, reset_n low): all stage valids, res_makes_rd, commit_br_valid clear. res_rd, result, commit_br, commit_br_addr, commit_br_short and commit_br_dec are all 0.
- S1 (edge after issue): register all lane inputs. s1_valid = enable & !commit_kill[rd].
- S2 (combinational on S1 regs), for cjmp:
  - need = eq / signed lt / unsigned lt by type.
  - mispredict = s1_valid & (predicted ^ invert ^ need).
  - target = predicted ? pc + (short ? 1 : 2) : pc + sext(immed) (halfword units, wraps mod 2^(RV-1)).
- S2 for jmp:
  - t = (pc_rel ? {pc,0} : r1) + sext(immed); target = t[RV-1:1].
  - mispredict = s1_valid & (!predicted | target != branch_dest).
- S2 lanes whose rd is in commit_kill this cycle are dropped: no mispredict, no writeback.
- Link writeback, registered one edge after S2: result = {pc + (short ? 1 : 2), 0}; res_rd = rd; res_makes_rd = s1_valid & makes_rd & !kill. Latency is 2 cycles from issue; writeback happens for both cjmp and jmp.
- Age: age(x) = (x - commit_head) mod NCOMMIT; smaller is older.
- Arbitration candidates: the pending redirect (if valid, not killed and not being accepted this cycle) and all S2 mispredicting lanes. The oldest wins. Equal slots cannot occur; if they do, the pending redirect wins, then the lowest lane.
- Redirect register:
  - Loaded with the winner at the clock edge. Losers are discarded, because younger mispredicts are squashed by the older redirect.
  - Holds stable while valid & !ready.
  - Clears on valid & ready unless a new winner loads the same edge.
  - Clears if commit_kill[commit_br_addr] is asserted while no new winner exists.
- Simultaneous accept plus new mispredict: the new one loads, so valid stays 1.
- Wrap-around: ages compare correctly across slot NCOMMIT-1 to 0.
- RV=32: same equations on 32-bit operands.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - Adds outputs stat_branches[31:0] (S2 valid branches retired), stat_mispredicts[31:0] (redirect loads) and stat_discards[31:0] (mispredicts lost arbitration).
  - Saturating counters, cleared by reset_n, plus input stat_clr (synchronous clear, priority over increment).
- When undefined: ports and counters absent, with identical functional behaviour otherwise.

Test Plan:
- Lane0 cjmp eq, r1=r2=5, predicted=0, inv=0, pc=0x1000>>1, immed=0x20 -> commit_br_valid 2 cycles after issue, commit_br=0x1020>>1, addr=rd.
- Lane0 jmp r1-rel predicted=1, r1=0x4000, immed=8, branch_dest=0x4008>>1, makes_rd -> no redirect; result=0x1004 (short=0), res_makes_rd=1.
- Same cycle: lane0 mispredict rd=7, lane1 mispredict rd=3, commit_head=5 -> only rd=7 reported; discard counter +1.
- Pending redirect rd=2 held with ready=0; new mispredict rd=30, head=28 -> redirect switches to rd=30; then ready=1 -> valid clears.
- commit_kill[rd] asserted in S1 and in S2 for two branches -> no redirect, no writeback; kill of pending slot clears valid.
- Assert reset_n low mid-redirect with ready=0 -> valid clears immediately (async); outputs zero; first issue after release behaves normally.

Source files
------------

// File: rtl/branch_multi_if.sv
// Bundle of issue, writeback and commit-redirect signals for branch_multi.
// BRANCH_STATS_EN adds the statistics clear input and counter outputs.
interface branch_multi_if #(
  parameter int RV         = 64,
  parameter int NLANE      = 2,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int BDEC       = 4,
  parameter int CNTRL_SIZE = 7
);
  logic [NLANE-1:0]            enable;
  logic [NLANE*CNTRL_SIZE-1:0] control;
  logic [NLANE*RV-1:0]         r1;
  logic [NLANE*RV-1:0]         r2;
  logic [NLANE*32-1:0]         immed;
  logic [NLANE*(RV-1)-1:0]     pc;
  logic [NLANE*(RV-1)-1:0]     branch_dest;
  logic [NLANE*LNCOMMIT-1:0]   rd;
  logic [NLANE-1:0]            makes_rd;
  logic [NCOMMIT-1:0]          commit_kill;
  logic [LNCOMMIT-1:0]         commit_head;
  logic [NLANE*LNCOMMIT-1:0]   res_rd;
  logic [NLANE-1:0]            res_makes_rd;
  logic [NLANE*RV-1:0]         result;
  logic                        commit_br_valid;
  logic                        commit_br_ready;
  logic [RV-2:0]               commit_br;
  logic [LNCOMMIT-1:0]         commit_br_addr;
  logic                        commit_br_short;
  logic [BDEC-2:0]             commit_br_dec;
`ifdef BRANCH_STATS_EN
  logic                        stat_clr;
  logic [31:0]                 stat_branches;
  logic [31:0]                 stat_mispredicts;
  logic [31:0]                 stat_discards;

  modport slave (
    input  enable, control, r1, r2, immed, pc, branch_dest, rd, makes_rd,
           commit_kill, commit_head, commit_br_ready, stat_clr,
    output res_rd, res_makes_rd, result, commit_br_valid, commit_br,
           commit_br_addr, commit_br_short, commit_br_dec,
           stat_branches, stat_mispredicts, stat_discards
  );
  modport master (
    output enable, control, r1, r2, immed, pc, branch_dest, rd, makes_rd,
           commit_kill, commit_head, commit_br_ready, stat_clr,
    input  res_rd, res_makes_rd, result, commit_br_valid, commit_br,
           commit_br_addr, commit_br_short, commit_br_dec,
           stat_branches, stat_mispredicts, stat_discards
  );
`else
  modport slave (
    input  enable, control, r1, r2, immed, pc, branch_dest, rd, makes_rd,
           commit_kill, commit_head, commit_br_ready,
    output res_rd, res_makes_rd, result, commit_br_valid, commit_br,
           commit_br_addr, commit_br_short, commit_br_dec
  );
  modport master (
    output enable, control, r1, r2, immed, pc, branch_dest, rd, makes_rd,
           commit_kill, commit_head, commit_br_ready,
    input  res_rd, res_makes_rd, result, commit_br_valid, commit_br,
           commit_br_addr, commit_br_short, commit_br_dec
  );
`endif
endinterface

// File: rtl/branch_multi.sv
// NLANE-wide branch/jump resolution: per-lane operand stage, compare/target stage, and an
// age-arbitrated redirect register toward commit. Define BRANCH_STATS_EN for statistics counters.
module branch_multi #(
  parameter int RV         = 64,
  parameter int NLANE      = 2,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int BDEC       = 4,
  parameter int CNTRL_SIZE = 7
) (
  input logic           clk,
  input logic           reset_n,
  branch_multi_if.slave bus
);
  typedef logic [RV-2:0]       hpc_t;
  typedef logic [LNCOMMIT-1:0] slot_t;

  logic [NLANE-1:0]                 s1_valid_q, s1_mk_q;
  logic [NLANE-1:0][CNTRL_SIZE-1:0] s1_ctrl_q;
  logic [NLANE-1:0][RV-1:0]         s1_r1_q, s1_r2_q;
  logic [NLANE-1:0][31:0]           s1_imm_q;
  logic [NLANE-1:0][RV-2:0]         s1_pc_q, s1_bd_q;
  logic [NLANE-1:0][LNCOMMIT-1:0]   s1_rd_q;

  logic [NLANE-1:0]                 s2_live, s2_mis, s2_need;
  logic [NLANE-1:0][RV-1:0]         s2_sum;
  logic [NLANE-1:0][RV-2:0]         s2_fall, s2_tgt;

  logic [NLANE-1:0][LNCOMMIT-1:0]   res_rd_q;
  logic [NLANE-1:0]                 res_mk_q;
  logic [NLANE-1:0][RV-1:0]         result_q;

  logic                             br_valid_q, br_valid_d;
  hpc_t                             br_tgt_q, br_tgt_d;
  slot_t                            br_addr_q, br_addr_d;
  logic                             br_short_q, br_short_d;
  logic [BDEC-2:0]                  br_dec_q, br_dec_d;

  logic                             pend_cand, have;
  slot_t                            best_age, lane_age;
  logic [NLANE-1:0]                 win_oh;
  logic                             unused_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= '0;
      s1_mk_q    <= '0;
      s1_ctrl_q  <= '0;
      s1_r1_q    <= '0;
      s1_r2_q    <= '0;
      s1_imm_q   <= '0;
      s1_pc_q    <= '0;
      s1_bd_q    <= '0;
      s1_rd_q    <= '0;
    end else begin
      for (int l = 0; l < NLANE; l++) begin
        s1_valid_q[l] <= bus.enable[l] & ~bus.commit_kill[bus.rd[l*LNCOMMIT +: LNCOMMIT]];
        s1_mk_q[l]    <= bus.makes_rd[l];
        s1_ctrl_q[l]  <= bus.control[l*CNTRL_SIZE +: CNTRL_SIZE];
        s1_r1_q[l]    <= bus.r1[l*RV +: RV];
        s1_r2_q[l]    <= bus.r2[l*RV +: RV];
        s1_imm_q[l]   <= bus.immed[l*32 +: 32];
        s1_pc_q[l]    <= bus.pc[l*(RV-1) +: (RV-1)];
        s1_bd_q[l]    <= bus.branch_dest[l*(RV-1) +: (RV-1)];
        s1_rd_q[l]    <= bus.rd[l*LNCOMMIT +: LNCOMMIT];
      end
    end
  end

  // Control: [5] predicted, [4] short, [3] invert, [2:1] type / [1] pc_rel, [0] cjmp
  always_comb begin
    s2_live = '0;
    s2_mis  = '0;
    s2_need = '0;
    s2_sum  = '0;
    s2_fall = '0;
    s2_tgt  = '0;
    for (int l = 0; l < NLANE; l++) begin
      s2_live[l] = s1_valid_q[l] & ~bus.commit_kill[s1_rd_q[l]];
      s2_fall[l] = s1_pc_q[l] + (s1_ctrl_q[l][4] ? hpc_t'(1) : hpc_t'(2));
      if (s1_ctrl_q[l][0] | s1_ctrl_q[l][1])
        s2_sum[l] = {s1_pc_q[l], 1'b0} + RV'($signed(s1_imm_q[l]));
      else
        s2_sum[l] = s1_r1_q[l] + RV'($signed(s1_imm_q[l]));
      case (s1_ctrl_q[l][2:1])
        2'd2:    s2_need[l] = $signed(s1_r1_q[l]) < $signed(s1_r2_q[l]);
        2'd3:    s2_need[l] = s1_r1_q[l] < s1_r2_q[l];
        default: s2_need[l] = s1_r1_q[l] == s1_r2_q[l];
      endcase
      if (s1_ctrl_q[l][0]) begin
        s2_tgt[l] = s1_ctrl_q[l][5] ? s2_fall[l] : s2_sum[l][RV-1:1];
        s2_mis[l] = s2_live[l] & (s1_ctrl_q[l][5] ^ s1_ctrl_q[l][3] ^ s2_need[l]);
      end else begin
        s2_tgt[l] = s2_sum[l][RV-1:1];
        s2_mis[l] = s2_live[l] & (~s1_ctrl_q[l][5] | (s2_sum[l][RV-1:1] != s1_bd_q[l]));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_rd_q <= '0;
      res_mk_q <= '0;
      result_q <= '0;
    end else begin
      for (int l = 0; l < NLANE; l++) begin
        res_rd_q[l] <= s1_rd_q[l];
        res_mk_q[l] <= s2_live[l] & s1_mk_q[l];
        result_q[l] <= {s2_fall[l], 1'b0};
      end
    end
  end

  // Oldest-first selection; strict compare keeps the pending redirect, then the lowest lane, on ties.
  always_comb begin
    pend_cand = br_valid_q & ~bus.commit_kill[br_addr_q] & ~bus.commit_br_ready;
    have      = pend_cand;
    best_age  = br_addr_q - bus.commit_head;
    lane_age  = '0;
    win_oh    = '0;
    for (int l = 0; l < NLANE; l++) begin
      lane_age = s1_rd_q[l] - bus.commit_head;
      if (s2_mis[l] && (!have || lane_age < best_age)) begin
        have      = 1'b1;
        best_age  = lane_age;
        win_oh    = '0;
        win_oh[l] = 1'b1;
      end
    end
  end

  always_comb begin
    br_valid_d = pend_cand | (|win_oh);
    br_tgt_d   = br_tgt_q;
    br_addr_d  = br_addr_q;
    br_short_d = br_short_q;
    br_dec_d   = br_dec_q;
    for (int l = 0; l < NLANE; l++) begin
      if (win_oh[l]) begin
        br_tgt_d   = s2_tgt[l];
        br_addr_d  = s1_rd_q[l];
        br_short_d = s1_ctrl_q[l][4];
        br_dec_d   = s1_pc_q[l][BDEC-2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_valid_q <= 1'b0;
      br_tgt_q   <= '0;
      br_addr_q  <= '0;
      br_short_q <= 1'b0;
      br_dec_q   <= '0;
    end else begin
      br_valid_q <= br_valid_d;
      br_tgt_q   <= br_tgt_d;
      br_addr_q  <= br_addr_d;
      br_short_q <= br_short_d;
      br_dec_q   <= br_dec_d;
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int l = 0; l < NLANE; l++)
      unused_bits = unused_bits ^ s2_sum[l][0] ^ (^s1_ctrl_q[l][CNTRL_SIZE-1:6]);
  end

  assign bus.res_rd          = res_rd_q;
  assign bus.res_makes_rd    = res_mk_q;
  assign bus.result          = result_q;
  assign bus.commit_br_valid = br_valid_q;
  assign bus.commit_br       = br_tgt_q;
  assign bus.commit_br_addr  = br_addr_q;
  assign bus.commit_br_short = br_short_q;
  assign bus.commit_br_dec   = br_dec_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] n_live, n_disc;
  logic [31:0] stat_br_q, stat_mis_q, stat_disc_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    n_live = '0;
    n_disc = '0;
    for (int l = 0; l < NLANE; l++) begin
      n_live = n_live + 32'(s2_live[l]);
      n_disc = n_disc + 32'(s2_mis[l] & ~win_oh[l]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q   <= '0;
      stat_mis_q  <= '0;
      stat_disc_q <= '0;
    end else if (bus.stat_clr) begin
      stat_br_q   <= '0;
      stat_mis_q  <= '0;
      stat_disc_q <= '0;
    end else begin
      stat_br_q   <= sat_add(stat_br_q, n_live);
      stat_mis_q  <= sat_add(stat_mis_q, {31'd0, |win_oh});
      stat_disc_q <= sat_add(stat_disc_q, n_disc);
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mis_q;
  assign bus.stat_discards    = stat_disc_q;
`endif
endmodule

// File: tb/tb_branch_multi.sv
// Bench for branch_multi: directed vector table, hand-written corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_branch_multi;
  localparam int RV = 64;
  localparam int NLANE = 2;
  localparam int NCOMMIT = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  branch_multi_if bus ();
  branch_multi dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [NLANE-1:0] en, mk;
  logic [6:0]       ctl [NLANE];
  logic [RV-1:0]    r1 [NLANE];
  logic [RV-1:0]    r2 [NLANE];
  logic [31:0]      imm [NLANE];
  logic [RV-2:0]    pc [NLANE];
  logic [RV-2:0]    bd [NLANE];
  logic [4:0]       rd [NLANE];
  logic [31:0]      kill;
  logic [4:0]       head;
  logic             ready;

  always_comb begin
    bus.enable          = en;
    bus.makes_rd        = mk;
    bus.commit_kill     = kill;
    bus.commit_head     = head;
    bus.commit_br_ready = ready;
    bus.control         = '0;
    bus.r1              = '0;
    bus.r2              = '0;
    bus.immed           = '0;
    bus.pc              = '0;
    bus.branch_dest     = '0;
    bus.rd              = '0;
    for (int l = 0; l < NLANE; l++) begin
      bus.control[l*7 +: 7]            = ctl[l];
      bus.r1[l*RV +: RV]               = r1[l];
      bus.r2[l*RV +: RV]               = r2[l];
      bus.immed[l*32 +: 32]            = imm[l];
      bus.pc[l*(RV-1) +: (RV-1)]       = pc[l];
      bus.branch_dest[l*(RV-1) +: (RV-1)] = bd[l];
      bus.rd[l*5 +: 5]                 = rd[l];
    end
`ifdef BRANCH_STATS_EN
    bus.stat_clr = 1'b0;
`endif
  end

  int n_checks = 0;
  int n_errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [6:0]  ctrl;
    logic [63:0] a, b;
    logic [31:0] i;
    logic [62:0] p, d;
    logic [4:0]  slot;
    bit          mk;
  } lane_t;

  typedef struct {
    int          age;
    logic [4:0]  slot;
    logic [62:0] tgt;
    bit          sh;
    logic [2:0]  dec;
  } cand_t;

  lane_t       m_s1 [NLANE];
  bit          m_rm [NLANE];
  logic [4:0]  m_rr [NLANE];
  logic [63:0] m_res [NLANE];
  bit          m_v;
  logic [62:0] m_br;
  logic [4:0]  m_addr;
  bit          m_short;
  logic [2:0]  m_dec;

  function automatic logic [63:0] sext(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic int age_of(input logic [4:0] s);
    return (int'(s) - int'(head) + NCOMMIT) % NCOMMIT;
  endfunction

  function automatic bit cond_true(input logic [1:0] typ, input logic [63:0] a, input logic [63:0] b);
    if (typ == 2'd2) return $signed(a) < $signed(b);
    if (typ == 2'd3) return a < b;
    return a == b;
  endfunction

  function automatic logic [62:0] jump_target(input logic [6:0] c, input logic [63:0] a,
                                              input logic [62:0] p, input logic [31:0] i);
    logic [63:0] t;
    t = (c[1] ? {p, 1'b0} : a) + sext(i);
    return t[63:1];
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NLANE; l++) begin
      m_s1[l] = '{v: 1'b0, ctrl: '0, a: '0, b: '0, i: '0, p: '0, d: '0, slot: '0, mk: 1'b0};
      m_rm[l] = 1'b0;
      m_rr[l] = '0;
      m_res[l] = '0;
    end
    m_v = 1'b0; m_br = '0; m_addr = '0; m_short = 1'b0; m_dec = '0;
  endtask

  task automatic model_edge();
    cand_t       q[$];
    cand_t       c;
    lane_t       s;
    bit          live, taken, mis;
    logic [62:0] fall, tgt;
    logic [63:0] t;
    int          best;
    if (m_v && !kill[m_addr] && !ready) begin
      c = '{age: age_of(m_addr), slot: m_addr, tgt: m_br, sh: m_short, dec: m_dec};
      q.push_back(c);
    end
    for (int l = 0; l < NLANE; l++) begin
      s = m_s1[l];
      live = s.v && !kill[s.slot];
      fall = s.p + (s.ctrl[4] ? 63'd1 : 63'd2);
      m_rm[l] = live && s.mk;
      m_rr[l] = s.slot;
      m_res[l] = {fall, 1'b0};
      if (live) begin
        if (s.ctrl[0]) begin
          taken = cond_true(s.ctrl[2:1], s.a, s.b) ^ s.ctrl[3];
          mis = taken != s.ctrl[5];
          t = {s.p, 1'b0} + sext(s.i);
          tgt = taken ? t[63:1] : fall;
        end else begin
          tgt = jump_target(s.ctrl, s.a, s.p, s.i);
          mis = !s.ctrl[5] || (tgt != s.d);
        end
        if (mis) begin
          c = '{age: age_of(s.slot), slot: s.slot, tgt: tgt, sh: s.ctrl[4], dec: s.p[2:0]};
          q.push_back(c);
        end
      end
    end
    best = -1;
    foreach (q[k]) if (best < 0 || q[k].age < q[best].age) best = k;
    if (best >= 0) begin
      m_v = 1'b1; m_br = q[best].tgt; m_addr = q[best].slot;
      m_short = q[best].sh; m_dec = q[best].dec;
    end else begin
      m_v = 1'b0;
    end
    for (int l = 0; l < NLANE; l++)
      m_s1[l] = '{v: en[l] && !kill[rd[l]], ctrl: ctl[l], a: r1[l], b: r2[l], i: imm[l],
                  p: pc[l], d: bd[l], slot: rd[l], mk: mk[l]};
  endtask

  task automatic compare_all();
    chk("br_valid", 64'(bus.commit_br_valid), 64'(m_v));
    if (m_v) begin
      chk("br_target", 64'(bus.commit_br), 64'(m_br));
      chk("br_addr", 64'(bus.commit_br_addr), 64'(m_addr));
      chk("br_short", 64'(bus.commit_br_short), 64'(m_short));
      chk("br_dec", 64'(bus.commit_br_dec), 64'(m_dec));
    end
    for (int l = 0; l < NLANE; l++) begin
      chk("res_makes_rd", 64'(bus.res_makes_rd[l]), 64'(m_rm[l]));
      if (m_rm[l]) begin
        chk("res_rd", 64'(bus.res_rd[l*5 +: 5]), 64'(m_rr[l]));
        chk("result", bus.result[l*RV +: RV], m_res[l]);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    en = '0;
    kill = '0;
  endtask

  task automatic set_lane(input int l, input logic [6:0] c, input logic [63:0] a, input logic [63:0] b,
                          input logic [31:0] i, input logic [62:0] p, input logic [62:0] d,
                          input logic [4:0] s, input bit m);
    en[l] = 1'b1; ctl[l] = c; r1[l] = a; r2[l] = b; imm[l] = i;
    pc[l] = p; bd[l] = d; rd[l] = s; mk[l] = m;
  endtask

  // cjmp eq, not predicted, equal operands: mispredicts to pc + 0x20 (halfwords)
  task automatic mis_lane(input int l, input logic [4:0] s);
    set_lane(l, 7'b0000001, 64'd0, 64'd0, 32'h40, 63'h400 + 63'(s), 63'd0, s, 1'b1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [6:0]  c;
    logic [63:0] a, b;
    logic [31:0] i;
    logic [62:0] p, d;
    bit          m;
    bit          ev;
    logic [62:0] ebr;
    bit          esh;
    logic [2:0]  edec;
    logic [63:0] eres;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{7'b0000001, 64'd5, 64'd5, 32'h20, 63'h800, 63'h0, 1'b1, 1'b1, 63'h810, 1'b0, 3'd0, 64'h1004};
    tbl[1] = '{7'b0000001, 64'd5, 64'd6, 32'h20, 63'h800, 63'h0, 1'b1, 1'b0, 63'h0, 1'b0, 3'd0, 64'h1004};
    tbl[2] = '{7'b0100101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h20, 63'h800, 63'h0, 1'b1, 1'b0, 63'h0, 1'b0, 3'd0, 64'h1004};
    tbl[3] = '{7'b0110111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h20, 63'h800, 63'h0, 1'b1, 1'b1, 63'h801, 1'b1, 3'd0, 64'h1002};
    tbl[4] = '{7'b0001001, 64'd5, 64'd5, 32'h20, 63'h800, 63'h0, 1'b0, 1'b0, 63'h0, 1'b0, 3'd0, 64'h0};
    tbl[5] = '{7'b0100000, 64'h4000, 64'd0, 32'h8, 63'h800, 63'h2004, 1'b1, 1'b0, 63'h0, 1'b0, 3'd0, 64'h1004};
    tbl[6] = '{7'b0100010, 64'd0, 64'd0, 32'hFFFF_FFF0, 63'h800, 63'h7F0, 1'b1, 1'b1, 63'h7F8, 1'b0, 3'd0, 64'h1004};
    tbl[7] = '{7'b0000000, 64'h4000, 64'd0, 32'h8, 63'h800, 63'h2004, 1'b1, 1'b1, 63'h2004, 1'b0, 3'd0, 64'h1004};
    tbl[8] = '{7'b0000001, 64'd0, 64'd0, 32'hFFFF_FF00, 63'h805, 63'h0, 1'b1, 1'b1, 63'h785, 1'b0, 3'd5, 64'h100E};

    reset_n = 1'b0;
    en = '0; mk = '0; kill = '0; head = '0; ready = 1'b1;
    for (int l = 0; l < NLANE; l++) begin
      ctl[l] = '0; r1[l] = '0; r2[l] = '0; imm[l] = '0; pc[l] = '0; bd[l] = '0; rd[l] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.commit_br_valid), 64'd0);
    chk("rst_br", 64'(bus.commit_br), 64'd0);
    chk("rst_addr", 64'(bus.commit_br_addr), 64'd0);
    chk("rst_short", 64'(bus.commit_br_short), 64'd0);
    chk("rst_dec", 64'(bus.commit_br_dec), 64'd0);
    chk("rst_res_mk", 64'(bus.res_makes_rd), 64'd0);
    chk("rst_res_rd", 64'(bus.res_rd), 64'd0);
    chk("rst_result", bus.result[63:0], 64'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      ready = 1'b1; head = '0;
      set_lane(0, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].i, tbl[i].p, tbl[i].d, 5'(i + 4), tbl[i].m);
      tick();
      idle();
      tick();
      chk("tbl_valid", 64'(bus.commit_br_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl_br", 64'(bus.commit_br), 64'(tbl[i].ebr));
        chk("tbl_addr", 64'(bus.commit_br_addr), 64'(i + 4));
        chk("tbl_short", 64'(bus.commit_br_short), 64'(tbl[i].esh));
        chk("tbl_dec", 64'(bus.commit_br_dec), 64'(tbl[i].edec));
      end
      chk("tbl_res_mk", 64'(bus.res_makes_rd[0]), 64'(tbl[i].m));
      if (tbl[i].m) chk("tbl_result", bus.result[63:0], tbl[i].eres);
      tick();
      tick();
    end

    // two lanes mispredict together: the older slot (7, age 2) beats 3 (age 30)
    head = 5'd5; ready = 1'b0;
    mis_lane(0, 5'd7);
    mis_lane(1, 5'd3);
    tick(); idle(); tick();
    chk("arb_valid", 64'(bus.commit_br_valid), 64'd1);
    chk("arb_addr", 64'(bus.commit_br_addr), 64'd7);
    ready = 1'b1;
    tick();
    chk("arb_accept", 64'(bus.commit_br_valid), 64'd0);

    // held redirect replaced by an older one across the slot wrap
    head = 5'd28; ready = 1'b0;
    mis_lane(0, 5'd2);
    tick(); idle(); tick();
    chk("hold_addr", 64'(bus.commit_br_addr), 64'd2);
    tick();
    chk("hold_valid", 64'(bus.commit_br_valid), 64'd1);
    chk("hold_addr2", 64'(bus.commit_br_addr), 64'd2);
    mis_lane(1, 5'd30);
    tick(); idle(); tick();
    chk("wrap_addr", 64'(bus.commit_br_addr), 64'd30);
    chk("wrap_br", 64'(bus.commit_br), 64'h43E);
    ready = 1'b1;
    tick();
    chk("wrap_accept", 64'(bus.commit_br_valid), 64'd0);

    // accept and new mispredict on the same edge
    head = 5'd0; ready = 1'b0;
    mis_lane(0, 5'd6);
    tick(); idle(); tick();
    mis_lane(0, 5'd9);
    tick(); idle();
    ready = 1'b1;
    tick();
    chk("acc_new_valid", 64'(bus.commit_br_valid), 64'd1);
    chk("acc_new_addr", 64'(bus.commit_br_addr), 64'd9);
    tick();
    chk("acc_new_clear", 64'(bus.commit_br_valid), 64'd0);

    // kills in S1, in S2, and of the pending slot
    mis_lane(0, 5'd9);
    kill = 32'h1 << 9;
    tick(); idle(); tick();
    chk("kill_s1_valid", 64'(bus.commit_br_valid), 64'd0);
    chk("kill_s1_wb", 64'(bus.res_makes_rd[0]), 64'd0);
    mis_lane(0, 5'd10);
    tick(); idle();
    kill = 32'h1 << 10;
    tick();
    chk("kill_s2_valid", 64'(bus.commit_br_valid), 64'd0);
    chk("kill_s2_wb", 64'(bus.res_makes_rd[0]), 64'd0);
    kill = '0; ready = 1'b0;
    mis_lane(0, 5'd11);
    tick(); idle(); tick();
    chk("kill_pend_pre", 64'(bus.commit_br_valid), 64'd1);
    kill = 32'h1 << 11;
    tick();
    chk("kill_pend_clr", 64'(bus.commit_br_valid), 64'd0);
    kill = '0;

    // asynchronous reset while a redirect is held
    mis_lane(0, 5'd12);
    tick(); idle(); tick();
    chk("areset_pre", 64'(bus.commit_br_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_valid", 64'(bus.commit_br_valid), 64'd0);
    chk("areset_addr", 64'(bus.commit_br_addr), 64'd0);
    chk("areset_br", 64'(bus.commit_br), 64'd0);
    chk("areset_wb", 64'(bus.res_makes_rd), 64'd0);
    chk("areset_result", bus.result[63:0], 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1; ready = 1'b1;
    set_lane(0, tbl[0].c, tbl[0].a, tbl[0].b, tbl[0].i, tbl[0].p, tbl[0].d, 5'd4, 1'b1);
    tick(); idle(); tick();
    chk("post_rst_valid", 64'(bus.commit_br_valid), 64'd1);
    chk("post_rst_br", 64'(bus.commit_br), 64'h810);
    chk("post_rst_result", bus.result[63:0], 64'h1004);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      for (int l = 0; l < NLANE; l++) begin
        logic [1:0] typ;
        en[l] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 2))
          0: typ = 2'd0;
          1: typ = 2'd2;
          default: typ = 2'd3;
        endcase
        ctl[l] = {1'b0, 1'($urandom), 1'($urandom), 1'($urandom), typ, 1'($urandom)};
        if (!ctl[l][0]) ctl[l][2] = 1'($urandom);
        r1[l] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 3));
        r2[l] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 3));
        imm[l] = 32'($urandom_range(0, 511)) - 32'd256;
        pc[l] = 63'({$urandom, $urandom});
        rd[l] = 5'($urandom_range(0, 31));
        mk[l] = 1'($urandom);
        bd[l] = ($urandom_range(0, 1) == 0) ? jump_target(ctl[l], r1[l], pc[l], imm[l])
                                             : 63'({$urandom, $urandom});
      end
      kill = '0;
      for (int k = 0; k < 32; k++) kill[k] = ($urandom_range(0, 15) == 0);
      head = 5'($urandom_range(0, 31));
      ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    idle();
    ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
